// File: rtl/memory_dump_reader.sv
// rtl/memory_dump_reader.sv - streams a range of main-memory words out with byte addresses
// Reads are throttled so issued-but-unconsumed words never exceed the 2-entry output FIFO.
module memory_dump_reader #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dump_start,
  input  logic [MEM_ADDRESS_BITS-1:0] dump_base,
  input  logic [MEM_ADDRESS_BITS:0]   dump_count,
  output logic                        mem_read_en,
  output logic [MEM_ADDRESS_BITS-1:0] mem_read_address,
  input  logic [DATA_WIDTH-1:0]       mem_read_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [ADDRESS_BITS-1:0]     out_address,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int MAW = MEM_ADDRESS_BITS;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  fifo_data_q [2];
  logic [MAW-1:0]         fifo_idx_q [2];
  logic [1:0]             fifo_last_q;
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             fifo_cnt_q;
  logic                   inflight_q;
  logic                   inflight_last_q;
  logic [MAW-1:0]         inflight_idx_q;
  logic [MAW-1:0]         next_idx_q;
  logic [MAW-1:0]         addr_hold_q;
  logic [MAW:0]           issue_left_q;

  logic                   fifo_valid;
  logic                   pop;
  logic [2:0]             occupancy;
  logic                   issue;

  assign fifo_valid = (fifo_cnt_q != 2'd0);
  assign pop        = fifo_valid & out_ready;
  assign occupancy  = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  // A slot freed by this cycle's pop may be reused by this cycle's issue.
  assign issue      = (state_q == READ) && (issue_left_q != '0) &&
                      (occupancy < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
      fifo_last_q     <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      fifo_cnt_q      <= 2'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_idx_q  <= '0;
      next_idx_q      <= '0;
      addr_hold_q     <= '0;
      issue_left_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_idx_q  <= next_idx_q;
        inflight_last_q <= (issue_left_q == (MAW+1)'(1));
        addr_hold_q     <= next_idx_q;
        next_idx_q      <= next_idx_q + MAW'(1);
        issue_left_q    <= issue_left_q - (MAW+1)'(1);
      end
      if (inflight_q) begin
        fifo_data_q[wr_ptr_q] <= mem_read_data;
        fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

      case (state_q)
        IDLE: begin
          if (dump_start) begin
            next_idx_q   <= dump_base;
            issue_left_q <= dump_count;
            state_q      <= (dump_count == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (issue && (issue_left_q == (MAW+1)'(1))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && fifo_last_q[rd_ptr_q]) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, not just after it is sampled.
  assign mem_read_en      = issue & ~reset;
  assign mem_read_address = reset ? '0 : (issue ? next_idx_q : addr_hold_q);
  assign out_valid        = fifo_valid & ~reset;
  assign out_data         = reset ? '0 : fifo_data_q[rd_ptr_q];
  assign out_address      = reset ? '0 :
                            ADDRESS_BITS'(fifo_idx_q[rd_ptr_q]) * ADDRESS_BITS'(DATA_WIDTH / 8);
  assign out_last         = fifo_last_q[rd_ptr_q] & fifo_valid & ~reset;
  assign busy             = (state_q != IDLE) & ~reset;
  assign done             = (state_q == DONE) & ~reset;

endmodule
